// File: rtl/m_store_buf_pkg.sv
// Shared constants and types for the M-stage store buffer: store-type
// encodings, FIFO depth and the aligned entry layout.
package m_store_buf_pkg;

  localparam logic [1:0] ST_SW  = 2'b00;
  localparam logic [1:0] ST_SH  = 2'b01;
  localparam logic [1:0] ST_SB  = 2'b10;
  localparam logic [1:0] ST_ILL = 2'b11;

  localparam int unsigned BUF_DEPTH = 2;

  // One buffered store, already lane-aligned: word address, byte enables, data.
  typedef struct packed {
    logic [29:0] waddr;
    logic [3:0]  be;
    logic [31:0] data;
  } entry_t;

endpackage

// File: rtl/m_st_align.sv
// Combinational store lane alignment: turns a right-justified register value
// and byte address into a word address, byte enables and replicated data.
module m_st_align
  import m_store_buf_pkg::*;
(
  input  logic [1:0]  st_type,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  output entry_t      entry,
  output logic        misalign
);

  always_comb begin
    entry.waddr = st_addr[31:2];
    entry.be    = 4'b0000;
    entry.data  = st_data;
    misalign    = 1'b0;
    case (st_type)
      ST_SW: begin
        entry.be = 4'b1111;
        misalign = (st_addr[1:0] != 2'b00);
      end
      ST_SH: begin
        entry.be   = st_addr[1] ? 4'b1100 : 4'b0011;
        entry.data = {2{st_data[15:0]}};
        misalign   = st_addr[0];
      end
      ST_SB: begin
        entry.be   = 4'b0001 << st_addr[1:0];
        entry.data = {4{st_data[7:0]}};
      end
      default: misalign = 1'b1;
    endcase
  end

endmodule

// File: rtl/m_store_buf.sv
// Two-entry store buffer between the M stage and data memory. Stores are
// aligned on entry and drained in order through a req/ack port.
//
// Handshakes: a store transfers on a rising edge where st_valid && st_ready and
// the store is legal; st_ready depends only on registered state. The memory
// side presents the head while mem_req is high and holds it until an edge with
// mem_req && mem_ack, which pops it; mem_ack without mem_req is ignored.
module m_store_buf
  import m_store_buf_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        st_valid,
  input  logic [1:0]  st_type,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  output logic        st_ready,
  output logic        st_err,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  output logic        buf_empty
);

  entry_t     entries [BUF_DEPTH];
  entry_t     new_entry;
  entry_t     head;
  logic       misalign;
  logic       wptr, rptr;
  logic [1:0] count;
  logic       push, pop;

  m_st_align u_align (
    .st_type  (st_type),
    .st_addr  (st_addr),
    .st_data  (st_data),
    .entry    (new_entry),
    .misalign (misalign)
  );

  // A full buffer refuses stores even while popping: no push-through.
  assign st_ready  = (count != 2'd2);
  assign mem_req   = (count != 2'd0);
  assign buf_empty = (count == 2'd0);
  assign push      = st_valid && st_ready && !misalign;
  assign pop       = mem_req && mem_ack;

  assign head      = entries[rptr];
  assign mem_addr  = {head.waddr, 2'b00};
  assign mem_be    = head.be;
  assign mem_wdata = head.data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count  <= 2'd0;
      wptr   <= 1'b0;
      rptr   <= 1'b0;
      st_err <= 1'b0;
    end else begin
      // Errors only fire on a store that would otherwise have been taken.
      st_err <= st_valid && st_ready && misalign;
      if (push) wptr <= ~wptr;
      if (pop)  rptr <= ~rptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage is qualified by count, so it needs no reset.
  always_ff @(posedge clk) begin
    if (push) entries[wptr] <= new_entry;
  end

endmodule
